// File: rtl/aes_pkg.sv
// Shared AES constants: forward/inverse S-box, Rcon, inverse-round FSM states,
// plus the InvShiftRows byte permutation (byte 0 = bits [127:120], column-major).
package aes_pkg;

  typedef enum logic [2:0] {IDLE, KEY, ARK, SUB, FIN, DONE} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Row r of column c takes the byte from column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[127 - 8*(4*c + rr) -: 8] = s[127 - 8*(4*((c - rr + 4) % 4) + rr) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Inverse AES S-box, one byte, combinational lookup.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/sbox.sv
// Forward AES S-box, one byte, combinational lookup.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = SBOX[din];

endmodule

// File: rtl/aes_inv_round_seq.sv
// Sequential inverse of one AES-128 round (no MixColumns):
// pt = InvSubBytes(InvShiftRows(ct ^ rk1)) ^ rk0, one S-box column per SUB cycle.
module aes_inv_round_seq
  import aes_pkg::*;
#(
  parameter int NR = 1,
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key128,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt
);

  generate
    if (NR != 1 || NK != 4) begin : g_param_check
      $error("aes_inv_round_seq supports only NR=1 and NK=4");
    end
  endgenerate

  state_t       state_reg, state_next;
  logic [1:0]   col_reg;
  logic [127:0] ct_reg, rk0_reg, rk1_reg, blk_reg, pt_reg;
  logic         out_valid_reg;
  logic         accept, release_pt;

  assign in_ready   = (state_reg == IDLE);
  assign accept     = in_valid && in_ready;
  assign release_pt = out_valid_reg && out_ready;
  assign out_valid  = out_valid_reg;
  assign pt         = pt_reg;

  // Key schedule: first round key from the latched cipher key.
  logic [31:0]  rot_w3, sub_w3, temp_w, w4, w5, w6, w7;
  logic [127:0] rk1_next;

  assign rot_w3 = {rk0_reg[23:0], rk0_reg[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key_sbox
      sbox u_sbox (
        .din  (rot_w3[31 - 8*gi -: 8]),
        .dout (sub_w3[31 - 8*gi -: 8])
      );
    end
  endgenerate

  assign temp_w   = sub_w3 ^ {RCON[0], 24'h000000};
  assign w4       = rk0_reg[127:96] ^ temp_w;
  assign w5       = rk0_reg[95:64]  ^ w4;
  assign w6       = rk0_reg[63:32]  ^ w5;
  assign w7       = rk0_reg[31:0]   ^ w6;
  assign rk1_next = {w4, w5, w6, w7};

  // SUB datapath: four inverse S-box lanes on the column selected by col_reg.
  logic [31:0] col_in, col_out;

  assign col_in = blk_reg[127 - 32*int'(col_reg) -: 32];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub_lane
      inv_sbox u_inv_sbox (
        .din  (col_in[31 - 8*gi -: 8]),
        .dout (col_out[31 - 8*gi -: 8])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = KEY;
      KEY:     state_next = ARK;
      ARK:     state_next = SUB;
      SUB:     if (col_reg == 2'd3) state_next = FIN;
      FIN:     state_next = DONE;
      DONE:    if (release_pt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // out_valid is registered off DONE, so it rises one edge after DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg       <= 2'd0;
      ct_reg        <= '0;
      rk0_reg       <= '0;
      rk1_reg       <= '0;
      blk_reg       <= '0;
      pt_reg        <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            ct_reg  <= ct;
            rk0_reg <= key128;
          end
        end
        KEY: rk1_reg <= rk1_next;
        ARK: blk_reg <= inv_shift_rows(ct_reg ^ rk1_reg);
        SUB: begin
          blk_reg[127 - 32*int'(col_reg) -: 32] <= col_out;
          col_reg <= col_reg + 2'd1;
        end
        FIN: pt_reg <= blk_reg ^ rk0_reg;
        DONE: out_valid_reg <= !release_pt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_seq.sv
// Scoreboard bench for aes_inv_round_seq: directed vectors, round trips through
// a bench-side forward round, back-pressure, abort-by-reset and busy-input cases.
module tb_aes_inv_round_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] ct = '0;
  logic [127:0] key128 = '0;
  logic         in_ready, out_valid;
  logic [127:0] pt;

  int checks = 0;
  int failures = 0;
  int txn = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   fsb[256];

  aes_inv_round_seq #(.NR(1), .NK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .key128    (key128),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Forward S-box derived from GF(2^8) inverse and the AES affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      fsb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_rk1(input logic [127:0] k);
    logic [31:0] rot, t, w4, w5, w6, w7;
    rot = {k[23:0], k[31:24]};
    t = {fsb[rot[31:24]], fsb[rot[23:16]], fsb[rot[15:8]], fsb[rot[7:0]]} ^ 32'h01000000;
    w4 = k[127:96] ^ t;
    w5 = k[95:64] ^ w4;
    w6 = k[63:32] ^ w5;
    w7 = k[31:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  // One forward round without MixColumns: ShiftRows(SubBytes(p ^ k)) ^ rk1.
  function automatic logic [127:0] model_enc(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] s, b, o;
    s = p ^ k;
    for (int i = 0; i < 16; i++) b[127 - 8*i -: 8] = fsb[s[127 - 8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = b[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o ^ model_rk1(k);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h want none", pt);
      end else begin
        txn++;
        $display("txn %0d pt=%h", txn, pt);
        check("pt", pt, exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_job", 128'(in_ready), 128'd1);
  endtask

  task automatic do_job(input logic [127:0] c, input logic [127:0] k,
                        input logic [127:0] e, input int hold, input bit keep);
    int n;
    logic [127:0] snap;
    wait_ready();
    ct = c;
    key128 = k;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    if (!keep) in_valid = 1'b0;
    ct = rnd128();
    key128 = rnd128();
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (keep) begin
        ct = rnd128();
        key128 = rnd128();
      end
    end
    check("latency", 128'(n), 128'd8);
    snap = pt;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_pt", pt, snap);
      check("hold_in_ready", 128'(in_ready), 128'd0);
      check("hold_out_valid", 128'(out_valid), 128'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("done_out_valid", 128'(out_valid), 128'd0);
    check("done_in_ready", 128'(in_ready), 128'd1);
  endtask

  task automatic abort_job(input logic [127:0] c, input logic [127:0] k);
    bit seen;
    wait_ready();
    ct = c;
    key128 = k;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_pt", pt, 128'd0);
    check("abort_in_ready", 128'(in_ready), 128'd1);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 128'(seen), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] fk, fp, rp, rk;
    int hold;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_pt", pt, 128'd0);
    check("reset_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;

    do_job({4{32'h62636363}}, 128'd0, {16{8'h52}}, 0, 1'b0);
    do_job(128'd0, 128'd0, {4{32'hab000000}}, 0, 1'b0);

    fk = 128'h000102030405060708090a0b0c0d0e0f;
    fp = 128'h00112233445566778899aabbccddeeff;
    do_job(model_enc(fp, fk), fk, fp, 0, 1'b0);

    do_job(128'd0, 128'd0, {4{32'hab000000}}, 20, 1'b0);

    do_job(model_enc(fp, fk), fk, fp, 0, 1'b1);
    do_job({4{32'h62636363}}, 128'd0, {16{8'h52}}, 0, 1'b0);

    abort_job(rnd128(), rnd128());
    do_job(model_enc(fp, fk), fk, fp, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      rp = rnd128();
      rk = rnd128();
      hold = int'($urandom_range(0, 2));
      do_job(model_enc(rp, rk), rk, rp, hold, 1'b0);
    end

    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
